// File: rtl/rail_pkg.sv
// Shared mode and FSM state encodings for the rail switch yard.
package rail_pkg;

   typedef enum logic [1:0] {
      MODE_PASS    = 2'd0,
      MODE_SWAP    = 2'd1,
      MODE_BCAST_A = 2'd2,
      MODE_BCAST_B = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SETTLE = 2'd2
   } state_e;

endpackage

// File: rtl/rail_out_reg.sv
// One-entry registered output stage; a held beat stays stable until taken.
module rail_out_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             can_accept_o
);

   logic             valid_q;
   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o      = valid_q;
   assign data_o       = data_q;
   assign can_accept_o = !valid_q || ready_i;

endmodule

// File: rtl/rail_switch_yard.sv
// Two-lane to two-output switch with drain/settle sequencing on mode changes.
module rail_switch_yard
   import rail_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] c_data,
   output logic             c_valid,
   input  logic             c_ready,
   output logic [WIDTH-1:0] d_data,
   output logic             d_valid,
   input  logic             d_ready,
   input  logic [1:0]       mode_req,
   input  logic             mode_req_valid,
   output logic             mode_req_ready,
   output logic [1:0]       mode_cur,
   output logic             busy
);

   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE);

   state_e          state_q, state_d;
   mode_e           mode_q, mode_d;
   mode_e           pend_q, pend_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            en_q;

   logic             c_acc, d_acc;
   logic             c_load, d_load;
   logic [WIDTH-1:0] c_din, d_din;
   logic             a_rdy_map, b_rdy_map, run, a_fire, b_fire;

   // Readies are held low until the first edge after reset release.
   assign run            = en_q && (state_q == ST_RUN);
   assign a_ready        = run && a_rdy_map;
   assign b_ready        = run && b_rdy_map;
   assign a_fire         = a_valid && a_ready;
   assign b_fire         = b_valid && b_ready;
   assign mode_req_ready = run;
   assign mode_cur       = mode_q;
   assign busy           = (state_q != ST_RUN);

   always_comb begin
      a_rdy_map = 1'b0;
      b_rdy_map = 1'b0;
      c_load    = 1'b0;
      d_load    = 1'b0;
      c_din     = a_data;
      d_din     = b_data;
      case (mode_q)
         MODE_PASS: begin
            a_rdy_map = c_acc;   b_rdy_map = d_acc;
            c_load = a_fire;     c_din = a_data;
            d_load = b_fire;     d_din = b_data;
         end
         MODE_SWAP: begin
            a_rdy_map = d_acc;   b_rdy_map = c_acc;
            c_load = b_fire;     c_din = b_data;
            d_load = a_fire;     d_din = a_data;
         end
         MODE_BCAST_A: begin
            a_rdy_map = c_acc && d_acc;
            c_load = a_fire;     c_din = a_data;
            d_load = a_fire;     d_din = a_data;
         end
         default: begin
            b_rdy_map = c_acc && d_acc;
            c_load = b_fire;     c_din = b_data;
            d_load = b_fire;     d_din = b_data;
         end
      endcase
   end

   rail_out_reg #(.WIDTH(WIDTH)) u_out_c (
      .clk(clk), .rst_n(rst_n), .load_i(c_load), .data_i(c_din),
      .ready_i(c_ready), .valid_o(c_valid), .data_o(c_data), .can_accept_o(c_acc)
   );

   rail_out_reg #(.WIDTH(WIDTH)) u_out_d (
      .clk(clk), .rst_n(rst_n), .load_i(d_load), .data_i(d_din),
      .ready_i(d_ready), .valid_o(d_valid), .data_o(d_data), .can_accept_o(d_acc)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (mode_req_valid && mode_req_ready && (mode_e'(mode_req) != mode_q)) begin
               pend_d  = mode_e'(mode_req);
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!c_valid && !d_valid) begin
               mode_d = pend_q;
               if (SETTLE == 0) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_SETTLE;
                  cnt_d   = SETTLE_LOAD;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q <= CW'(1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         mode_q  <= MODE_PASS;
         pend_q  <= MODE_PASS;
         cnt_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         en_q    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rail_switch_yard.sv
// Scoreboard bench for rail_switch_yard: lane beats queued per mode, checked as outputs drain.
module tb_rail_switch_yard;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] a_data = '0, b_data = '0;
   logic       a_valid = 1'b0, b_valid = 1'b0;
   logic       a_ready, b_ready;
   logic [7:0] c_data, d_data;
   logic       c_valid, d_valid;
   logic       c_ready = 1'b1, d_ready = 1'b1;
   logic [1:0] mode_req = '0;
   logic       mode_req_valid = 1'b0;
   logic       mode_req_ready;
   logic [1:0] mode_cur;
   logic       busy;

   int         tests = 0;
   int         failed = 0;
   logic [1:0] tb_mode = 2'd0;
   logic [7:0] qc[$];
   logic [7:0] qd[$];

   rail_switch_yard #(.WIDTH(8), .SETTLE(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
      .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready),
      .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
      .mode_cur(mode_cur), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      failed++;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change only just after a rising edge, so negedge values are what the next edge sees.
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_valid && a_ready) begin
            case (tb_mode)
               2'd0: qc.push_back(a_data);
               2'd1: qd.push_back(a_data);
               2'd2: begin qc.push_back(a_data); qd.push_back(a_data); end
               default: begin
                  tests++; failed++;
                  $display("FAIL a_fire_in_bcast_b: a accepted (%h) while B broadcasts", a_data);
               end
            endcase
         end
         if (b_valid && b_ready) begin
            case (tb_mode)
               2'd0: qd.push_back(b_data);
               2'd1: qc.push_back(b_data);
               2'd3: begin qc.push_back(b_data); qd.push_back(b_data); end
               default: begin
                  tests++; failed++;
                  $display("FAIL b_fire_in_bcast_a: b accepted (%h) while A broadcasts", b_data);
               end
            endcase
         end
         if (c_valid && c_ready) begin
            tests++;
            if (qc.size() == 0) begin
               failed++;
               $display("FAIL c_extra: got %h, expected no beat", c_data);
            end else begin
               automatic logic [7:0] e = qc.pop_front();
               if (c_data !== e) begin
                  failed++;
                  $display("FAIL c_data: got %h, expected %h", c_data, e);
               end
            end
         end
         if (d_valid && d_ready) begin
            tests++;
            if (qd.size() == 0) begin
               failed++;
               $display("FAIL d_extra: got %h, expected no beat", d_data);
            end else begin
               automatic logic [7:0] e = qd.pop_front();
               if (d_data !== e) begin
                  failed++;
                  $display("FAIL d_data: got %h, expected %h", d_data, e);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 20) begin
         step();
         n++;
      end
      tests++;
      if (busy !== 1'b0) begin
         failed++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
      end
   endtask

   task automatic test_reset();
      step();
      #1;
      tests++;
      if ({a_ready, b_ready, mode_req_ready, c_valid, d_valid, busy} !== 6'b0) begin
         failed++;
         $display("FAIL reset_flags: a_rdy b_rdy m_rdy c_v d_v busy = %b, expected 000000",
                  {a_ready, b_ready, mode_req_ready, c_valid, d_valid, busy});
      end
      tests++;
      if (mode_cur !== 2'd0 || c_data !== 8'h00 || d_data !== 8'h00) begin
         failed++;
         $display("FAIL reset_vals: mode=%0d c=%h d=%h, expected 0 00 00", mode_cur, c_data, d_data);
      end
      step();
      rst_n = 1'b1;
      #1;
      tests++;
      if (a_ready !== 1'b0 || mode_req_ready !== 1'b0) begin
         failed++;
         $display("FAIL ready_before_edge: a_rdy=%b m_rdy=%b, expected 0 0", a_ready, mode_req_ready);
      end
      step();
      tests++;
      if ({a_ready, b_ready, mode_req_ready} !== 3'b111) begin
         failed++;
         $display("FAIL ready_after_edge: %b, expected 111", {a_ready, b_ready, mode_req_ready});
      end
   endtask

   task automatic test_pass();
      a_data = 8'b10010010; b_data = 8'b00011110;
      a_valid = 1'b1; b_valid = 1'b1;
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      tests++;
      if (c_valid !== 1'b1 || d_valid !== 1'b1 || c_data !== 8'b10010010 || d_data !== 8'b00011110) begin
         failed++;
         $display("FAIL pass_latency: c_v=%b c=%h d_v=%b d=%h, expected 1 92 1 1e",
                  c_valid, c_data, d_valid, d_data);
      end
      step();
   endtask

   task automatic test_same_mode();
      mode_req = 2'd0; mode_req_valid = 1'b1;
      a_data = 8'h3C; a_valid = 1'b1;
      #1;
      tests++;
      if (mode_req_ready !== 1'b1 || a_ready !== 1'b1) begin
         failed++;
         $display("FAIL same_mode_accept: m_rdy=%b a_rdy=%b, expected 1 1", mode_req_ready, a_ready);
      end
      step();
      mode_req_valid = 1'b0; a_valid = 1'b0;
      #1;
      tests++;
      if (busy !== 1'b0 || a_ready !== 1'b1 || mode_cur !== 2'd0) begin
         failed++;
         $display("FAIL same_mode_noop: busy=%b a_rdy=%b mode=%0d, expected 0 1 0", busy, a_ready, mode_cur);
      end
      step();
   endtask

   task automatic test_swap();
      c_ready = 1'b0; d_ready = 1'b1;
      a_data = 8'h55; a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      mode_req = 2'd1; mode_req_valid = 1'b1;
      #1;
      tests++;
      if (mode_req_ready !== 1'b1) begin
         failed++;
         $display("FAIL swap_req_ready: %b, expected 1", mode_req_ready);
      end
      step();
      mode_req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if ({busy, a_ready, b_ready} !== 3'b100 || mode_cur !== 2'd0) begin
            failed++;
            $display("FAIL drain_hold[%0d]: busy,a_rdy,b_rdy=%b mode=%0d, expected 100 0",
                     i, {busy, a_ready, b_ready}, mode_cur);
         end
         step();
      end
      c_ready = 1'b1;
      step();
      step();
      tests++;
      if (mode_cur !== 2'd1 || busy !== 1'b1) begin
         failed++;
         $display("FAIL drain_edge: mode=%0d busy=%b, expected 1 1", mode_cur, busy);
      end
      tb_mode = 2'd1;
      for (int i = 0; i < 2; i++) begin
         step();
         tests++;
         if (busy !== 1'b1 || a_ready !== 1'b0) begin
            failed++;
            $display("FAIL settle[%0d]: busy=%b a_rdy=%b, expected 1 0", i, busy, a_ready);
         end
      end
      step();
      tests++;
      if (busy !== 1'b0 || a_ready !== 1'b1) begin
         failed++;
         $display("FAIL settle_end: busy=%b a_rdy=%b, expected 0 1", busy, a_ready);
      end
      a_data = 8'b10011010; a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      tests++;
      if (d_valid !== 1'b1 || d_data !== 8'b10011010 || c_valid !== 1'b0) begin
         failed++;
         $display("FAIL swap_route: d_v=%b d=%h c_v=%b, expected 1 9a 0", d_valid, d_data, c_valid);
      end
      step();
   endtask

   task automatic test_bcast_a();
      mode_req = 2'd2; mode_req_valid = 1'b1;
      step();
      mode_req_valid = 1'b0;
      wait_idle();
      tb_mode = 2'd2;
      tests++;
      if (mode_cur !== 2'd2) begin
         failed++;
         $display("FAIL bcast_mode: mode=%0d, expected 2", mode_cur);
      end
      c_ready = 1'b1; d_ready = 1'b0;
      a_data = 8'h11; a_valid = 1'b1;
      step();
      a_data = 8'b11010010;
      for (int i = 0; i < 2; i++) begin
         #1;
         tests++;
         if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failed++;
            $display("FAIL bcast_block[%0d]: a_rdy=%b b_rdy=%b, expected 0 0", i, a_ready, b_ready);
         end
         step();
      end
      d_ready = 1'b1;
      #1;
      tests++;
      if (a_ready !== 1'b1) begin
         failed++;
         $display("FAIL bcast_release: a_rdy=%b, expected 1", a_ready);
      end
      step();
      a_valid = 1'b0;
      tests++;
      if (c_valid !== 1'b1 || d_valid !== 1'b1 || c_data !== 8'b11010010 || d_data !== 8'b11010010) begin
         failed++;
         $display("FAIL bcast_both: c_v=%b c=%h d_v=%b d=%h, expected 1 d2 1 d2",
                  c_valid, c_data, d_valid, d_data);
      end
      step();
      step();
   endtask

   task automatic test_back_to_back();
      logic [7:0] nxt = 8'h40;
      logic       fire;
      mode_req = 2'd0; mode_req_valid = 1'b1;
      step();
      mode_req_valid = 1'b0;
      wait_idle();
      tb_mode = 2'd0;
      d_ready = 1'b1;
      a_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         c_ready = ((i % 3) != 0);
         a_data = nxt;
         #1;
         fire = a_ready;
         step();
         if (fire) nxt = nxt + 8'd1;
      end
      a_valid = 1'b0; c_ready = 1'b1;
      step(); step(); step();
      tests++;
      if (qc.size() != 0 || c_valid !== 1'b0) begin
         failed++;
         $display("FAIL backpressure_drain: %0d beats pending, c_v=%b, expected 0 0", qc.size(), c_valid);
      end
   endtask

   task automatic test_reset_mid_settle();
      c_ready = 1'b1; d_ready = 1'b1;
      mode_req = 2'd1; mode_req_valid = 1'b1;
      step();
      mode_req_valid = 1'b0;
      step();
      tests++;
      if (busy !== 1'b1 || mode_cur !== 2'd1) begin
         failed++;
         $display("FAIL settle_entry: busy=%b mode=%0d, expected 1 1", busy, mode_cur);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (mode_cur !== 2'd0 || busy !== 1'b0 || c_valid !== 1'b0 || d_valid !== 1'b0 || a_ready !== 1'b0) begin
         failed++;
         $display("FAIL reset_in_settle: mode=%0d busy=%b c_v=%b d_v=%b a_rdy=%b, expected 0 0 0 0 0",
                  mode_cur, busy, c_valid, d_valid, a_ready);
      end
      qc.delete(); qd.delete();
      tb_mode = 2'd0;
      step();
      rst_n = 1'b1;
      step();
      step();
      tests++;
      if (busy !== 1'b0 || mode_cur !== 2'd0 || a_ready !== 1'b1) begin
         failed++;
         $display("FAIL after_reset: busy=%b mode=%0d a_rdy=%b, expected 0 0 1", busy, mode_cur, a_ready);
      end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_same_mode();
      test_swap();
      test_bcast_a();
      test_back_to_back();
      test_reset_mid_settle();
      tests++;
      if (qc.size() != 0 || qd.size() != 0) begin
         failed++;
         $display("FAIL scoreboard_empty: c pending %0d d pending %0d, expected 0 0", qc.size(), qd.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
